// File: rtl/uart_tx_buffered_pkg.sv
// rtl/uart_tx_buffered_pkg.sv - shared UART framing constants and FSM state encodings
package uart_tx_buffered_pkg;

  // Payload width of one UART character (8N1 framing)
  localparam int UART_DATA_BITS = 8;

  // Level the serial line rests at between frames and during the stop bit
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Serializer states; kept as plain constants so the uart_rx side can share them
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - synchronous byte FIFO with extra-MSB full/empty detection
module uart_byte_fifo
  import uart_tx_buffered_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  uart_byte_t                 push_data_i,
  input  logic                       pop_i,
  output uart_byte_t                 pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  uart_byte_t    mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          push_ok;
  logic          pop_ok;

  // Pointers share the low bits for addressing; the MSB tells full from empty
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = CW'(wr_ptr_q - rd_ptr_q);

  // Requests are gated here so callers may assert push/pop unconditionally
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values; both may advance in the same cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset flushes the FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered 8N1 UART transmitter with valid/ready byte input
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter logic [15:0] CLKS_PER_BIT = 16'd10416,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [7:0]                      s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic                            utx,
  output logic                            busy,
  output logic                            tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  uart_byte_t  shift_q, shift_d;
  logic        utx_q, utx_d;
  logic        busy_q, busy_d;
  logic        tx_done_q, tx_done_d;

  logic        fifo_pop;
  uart_byte_t  fifo_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic        bit_end;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (s_valid),
    .push_data_i (s_data),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Ready depends only on FIFO occupancy, so a pop in the same cycle never frees a slot early
  assign s_ready = !fifo_full;

  assign bit_end = (clk_cnt_q == CLKS_PER_BIT - 16'd1);

  // Serializer next-state: bit timing, shifting and FIFO pops
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          // Chain straight into the next start bit so frames leave with no idle gap
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_data;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clk_cnt_d = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  // Line, busy and done are derived from the current state and registered together,
  // so all three stay aligned with each other one cycle behind the FSM
  always_comb begin
    utx_d     = UART_IDLE_LEVEL;
    busy_d    = (state_q != ST_IDLE);
    tx_done_d = (state_q == ST_STOP) && bit_end;
    case (state_q)
      ST_START: utx_d = ~UART_IDLE_LEVEL;
      ST_DATA:  utx_d = shift_q[0];
      default:  utx_d = UART_IDLE_LEVEL;
    endcase
  end

  // State and output registers; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      utx_q     <= UART_IDLE_LEVEL;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      utx_q     <= utx_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign utx     = utx_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - directed self-checking bench for uart_tx_buffered
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       utx;
  logic       busy;
  logic       tx_done;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Receiver model state
  logic       rx_active = 1'b0;
  int         rx_pos = 0;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rx_bytes[$];
  int         starts[$];
  int         frame_err = 0;
  int         done_cnt = 0;

  uart_tx_buffered #(
    .CLKS_PER_BIT (16'(CPB)),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .utx        (utx),
    .busy       (busy),
    .tx_done    (tx_done),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Independent 8N1 receiver sampling mid-bit on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_active <= 1'b0;
    end else if (!rx_active) begin
      if (!utx) begin
        rx_active <= 1'b1;
        rx_pos    <= 1;
        starts.push_back(cyc);
      end
    end else begin
      rx_pos <= rx_pos + 1;
      if (rx_pos == 2 && utx) frame_err <= frame_err + 1;
      if (rx_pos >= 6 && rx_pos <= 34 && ((rx_pos - 6) % CPB) == 0)
        rx_sh <= {utx, rx_sh[7:1]};
      if (rx_pos == 38) begin
        rx_active <= 1'b0;
        rx_bytes.push_back(rx_sh);
        if (!utx) frame_err <= frame_err + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a byte and hold s_valid until it is taken; s_valid is left high
  task automatic push_byte(input logic [7:0] b);
    logic accepted;
    accepted = 1'b0;
    s_data   = b;
    s_valid  = 1'b1;
    for (int n = 0; n < 400 && !accepted; n++) begin
      accepted = s_ready;
      tick();
    end
    check($sformatf("push_%02h", b), 32'(accepted), 32'd1);
  endtask

  task automatic wait_rx(input int n, input string tag);
    for (int i = 0; i < 1000 && rx_bytes.size() < n; i++) tick();
    check(tag, 32'(rx_bytes.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 1000 && (busy || fifo_count != 3'd0); i++) tick();
    check(tag, 32'(!busy && fifo_count == 3'd0), 32'd1);
  endtask

  initial begin
    int         base_d;
    int         base_r;
    int         base_s;
    int         bad_utx;
    int         bad_done;
    logic [9:0] fr;
    logic [7:0] exp3 [3];
    logic [7:0] exp4 [6];
    logic [7:0] exp5 [4];

    // 1: reset
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_utx", 32'(utx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd1);
    check("rst_done", 32'(tx_done), 32'd0);
    rst_n = 1'b1;
    tick();

    // 2: single byte 9D, bit-exact waveform
    base_d = done_cnt;
    base_r = rx_bytes.size();
    fr = {1'b1, 8'h9D, 1'b0};
    push_byte(8'h9D);
    s_valid = 1'b0;
    for (int k = 0; k < 42; k++) begin
      tick();
      if (k == 0 || k == 41) begin
        check($sformatf("t2_utx_%0d", k), 32'(utx), 32'd1);
        check($sformatf("t2_busy_%0d", k), 32'(busy), 32'd0);
      end else begin
        check($sformatf("t2_utx_%0d", k), 32'(utx), 32'(fr[(k-1)/CPB]));
        check($sformatf("t2_busy_%0d", k), 32'(busy), 32'd1);
      end
      check($sformatf("t2_done_%0d", k), 32'(tx_done), 32'(k == 40));
    end
    check("t2_done_cnt", 32'(done_cnt - base_d), 32'd1);
    check("t2_rx_cnt", 32'(rx_bytes.size() - base_r), 32'd1);
    if (rx_bytes.size() > base_r) check("t2_rx_byte", 32'(rx_bytes[base_r]), 32'h9D);

    // 3: three back-to-back frames at 40-cycle pitch
    exp3[0] = 8'd6; exp3[1] = 8'd17; exp3[2] = 8'd157;
    base_d = done_cnt;
    base_r = rx_bytes.size();
    base_s = starts.size();
    for (int i = 0; i < 3; i++) push_byte(exp3[i]);
    s_valid = 1'b0;
    wait_rx(base_r + 3, "t3_rx_timeout");
    wait_idle("t3_idle_timeout");
    for (int i = 0; i < 3; i++)
      if (rx_bytes.size() > base_r + i)
        check($sformatf("t3_byte_%0d", i), 32'(rx_bytes[base_r+i]), 32'(exp3[i]));
    check("t3_starts", 32'(starts.size() - base_s), 32'd3);
    if (starts.size() >= base_s + 3) begin
      check("t3_pitch_0", 32'(starts[base_s+1] - starts[base_s]), 32'd40);
      check("t3_pitch_1", 32'(starts[base_s+2] - starts[base_s+1]), 32'd40);
    end
    check("t3_done_cnt", 32'(done_cnt - base_d), 32'd3);

    // 4: fill the FIFO while holding s_valid
    exp4[0] = 8'h11; exp4[1] = 8'h22; exp4[2] = 8'h33;
    exp4[3] = 8'h44; exp4[4] = 8'h55; exp4[5] = 8'h66;
    base_d = done_cnt;
    base_r = rx_bytes.size();
    for (int i = 0; i < 5; i++) push_byte(exp4[i]);
    s_data = exp4[5];
    tick();
    tick();
    check("t4_ready_full", 32'(s_ready), 32'd0);
    check("t4_count_full", 32'(fifo_count), 32'd4);
    push_byte(exp4[5]);
    s_valid = 1'b0;
    wait_rx(base_r + 6, "t4_rx_timeout");
    wait_idle("t4_idle_timeout");
    for (int i = 0; i < 6; i++)
      if (rx_bytes.size() > base_r + i)
        check($sformatf("t4_byte_%0d", i), 32'(rx_bytes[base_r+i]), 32'(exp4[i]));
    check("t4_done_cnt", 32'(done_cnt - base_d), 32'd6);

    // 5: push and pop on the same edge with two bytes waiting
    exp5[0] = 8'hA1; exp5[1] = 8'hB2; exp5[2] = 8'hC3; exp5[3] = 8'hD4;
    base_r = rx_bytes.size();
    for (int i = 0; i < 3; i++) push_byte(exp5[i]);
    s_valid = 1'b0;
    repeat (38) tick();
    check("t5_count_before", 32'(fifo_count), 32'd2);
    check("t5_ready_before", 32'(s_ready), 32'd1);
    s_data  = exp5[3];
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    check("t5_count_after", 32'(fifo_count), 32'd2);
    check("t5_done_same_edge", 32'(tx_done), 32'd1);
    wait_rx(base_r + 4, "t5_rx_timeout");
    wait_idle("t5_idle_timeout");
    check("t5_rx_cnt", 32'(rx_bytes.size() - base_r), 32'd4);
    for (int i = 0; i < 4; i++)
      if (rx_bytes.size() > base_r + i)
        check($sformatf("t5_byte_%0d", i), 32'(rx_bytes[base_r+i]), 32'(exp5[i]));

    // 6: reset in the middle of a DATA phase with bytes queued
    push_byte(8'hA5);
    push_byte(8'h5A);
    push_byte(8'h77);
    s_valid = 1'b0;
    repeat (10) tick();
    check("t6_busy_mid", 32'(busy), 32'd1);
    base_d = done_cnt;
    base_r = rx_bytes.size();
    rst_n = 1'b0;
    tick();
    check("t6_rst_utx", 32'(utx), 32'd1);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_count", 32'(fifo_count), 32'd0);
    check("t6_rst_done", 32'(tx_done), 32'd0);
    check("t6_rst_ready", 32'(s_ready), 32'd1);
    rst_n = 1'b1;
    bad_utx  = 0;
    bad_done = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!utx) bad_utx++;
      if (tx_done) bad_done++;
    end
    check("t6_line_quiet", 32'(bad_utx), 32'd0);
    check("t6_no_done", 32'(bad_done), 32'd0);
    check("t6_no_rx", 32'(rx_bytes.size() - base_r), 32'd0);
    push_byte(8'h3C);
    s_valid = 1'b0;
    wait_rx(base_r + 1, "t6_rx_timeout");
    wait_idle("t6_idle_timeout");
    if (rx_bytes.size() > base_r) check("t6_byte", 32'(rx_bytes[base_r]), 32'h3C);
    check("t6_done_cnt", 32'(done_cnt - base_d), 32'd1);

    check("frame_errors", 32'(frame_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
